// File: rtl/pkt_tx_builder_pkg.sv
// Shared encodings for the packet transmit builder: packet kinds, word counts,
// broadcast ID and FSM state type.
package pkt_tx_builder_pkg;

   localparam logic [1:0] PKT_HB   = 2'd1;
   localparam logic [1:0] PKT_MR   = 2'd2;
   localparam logic [1:0] PKT_DATA = 2'd3;

   localparam logic [3:0] LEN_HB   = 4'd6;
   localparam logic [3:0] LEN_MR   = 4'd8;
   localparam logic [3:0] LEN_DATA = 4'd9;

   localparam logic [15:0] BCAST_ID = 16'hFFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_DONE
   } state_t;

   function automatic logic [3:0] pkt_len(input logic [1:0] i_type);
      case (i_type)
         PKT_HB:   pkt_len = LEN_HB;
         PKT_MR:   pkt_len = LEN_MR;
         PKT_DATA: pkt_len = LEN_DATA;
         default:  pkt_len = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/pkt_word_mux.sv
// Combinational selection of the outgoing packet word from packet kind and
// word index; word 0 is always the header.
module pkt_word_mux
   import pkt_tx_builder_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 16
) (
   input  logic [1:0]            i_type,
   input  logic [3:0]            i_idx,
   input  logic [WORD_WIDTH-1:0] i_header,
   input  logic [WORD_WIDTH-1:0] i_node_id,
   input  logic [WORD_WIDTH-1:0] i_hops,
   input  logic [WORD_WIDTH-1:0] i_qvalue,
   input  logic [WORD_WIDTH-1:0] i_energy,
   input  logic [WORD_WIDTH-1:0] i_hops_ch,
   input  logic [WORD_WIDTH-1:0] i_chosen_ch,
   input  logic [WORD_WIDTH-1:0] i_next_hop,
   input  logic [WORD_WIDTH-1:0] i_next_cnt,
   input  logic [WORD_WIDTH-1:0] i_payload,
   output logic [WORD_WIDTH-1:0] o_word
);

   always_comb begin
      o_word = '0;
      case (i_type)
         PKT_HB: begin
            case (i_idx)
               4'd0:    o_word = i_header;
               4'd1:    o_word = WORD_WIDTH'(BCAST_ID);
               4'd2:    o_word = i_node_id;
               4'd3:    o_word = i_hops;
               4'd4:    o_word = i_qvalue;
               4'd5:    o_word = i_energy;
               default: o_word = '0;
            endcase
         end
         PKT_MR: begin
            case (i_idx)
               4'd0:    o_word = i_header;
               4'd1:    o_word = i_chosen_ch;
               4'd2:    o_word = i_node_id;
               4'd3:    o_word = i_hops;
               4'd4:    o_word = i_qvalue;
               4'd5:    o_word = i_energy;
               4'd6:    o_word = i_hops_ch;
               4'd7:    o_word = i_chosen_ch;
               default: o_word = '0;
            endcase
         end
         PKT_DATA: begin
            // DATA carries the next hop's count in place of our own hop count
            case (i_idx)
               4'd0:    o_word = i_header;
               4'd1:    o_word = i_next_hop;
               4'd2:    o_word = i_node_id;
               4'd3:    o_word = i_next_cnt;
               4'd4:    o_word = i_qvalue;
               4'd5:    o_word = i_energy;
               4'd6:    o_word = i_hops_ch;
               4'd7:    o_word = i_chosen_ch;
               4'd8:    o_word = i_payload;
               default: o_word = '0;
            endcase
         end
         default: o_word = '0;
      endcase
   end

endmodule

// File: rtl/pkt_tx_builder.sv
// Builds HB/MR/DATA packets from snapshotted node fields and streams them to
// the radio over a valid/ready word interface.
module pkt_tx_builder
   import pkt_tx_builder_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned SEQ_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic [1:0]            pktType,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   input  logic [WORD_WIDTH-1:0] myHops,
   input  logic [WORD_WIDTH-1:0] myQValue,
   input  logic [WORD_WIDTH-1:0] myEnergy,
   input  logic [WORD_WIDTH-1:0] hopsFromCH,
   input  logic [WORD_WIDTH-1:0] chosenCH,
   input  logic [WORD_WIDTH-1:0] nextHop,
   input  logic [WORD_WIDTH-1:0] nextHopCount,
   input  logic [WORD_WIDTH-1:0] payload,
   input  logic                  abort,
   output logic [WORD_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  tx_last,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_type;
   logic [3:0]            r_idx;
   logic [SEQ_WIDTH-1:0]  r_seq;
   logic                  r_err;
   logic [WORD_WIDTH-1:0] r_node_id, r_hops, r_qvalue, r_energy, r_hops_ch;
   logic [WORD_WIDTH-1:0] r_chosen_ch, r_next_hop, r_next_cnt, r_payload;

   logic                  w_snap, w_adv, w_seq_inc, w_err_set;
   logic                  w_reject, w_last;
   logic [3:0]            w_len;
   logic [WORD_WIDTH-1:0] w_header, w_word;

   assign w_len    = pkt_len(r_type);
   assign w_last   = (r_idx == w_len - 4'd1);
   assign w_reject = (r_type == 2'd0) ||
                     ((r_type == PKT_DATA) && (r_next_hop == WORD_WIDTH'(BCAST_ID)));
   assign w_header = WORD_WIDTH'({2'b00, r_type, w_len, 8'(r_seq)});

   pkt_word_mux #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_word_mux (
      .i_type      (r_type),
      .i_idx       (r_idx),
      .i_header    (w_header),
      .i_node_id   (r_node_id),
      .i_hops      (r_hops),
      .i_qvalue    (r_qvalue),
      .i_energy    (r_energy),
      .i_hops_ch   (r_hops_ch),
      .i_chosen_ch (r_chosen_ch),
      .i_next_hop  (r_next_hop),
      .i_next_cnt  (r_next_cnt),
      .i_payload   (r_payload),
      .o_word      (w_word)
   );

   always_ff @(posedge clk) begin
      if (nrst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Abort wins over both rejection and a same-cycle handshake
   always_comb begin
      w_state_nxt = r_state;
      w_snap      = 1'b0;
      w_adv       = 1'b0;
      w_seq_inc   = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_snap      = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_reject) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (tx_ready) begin
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_adv = 1'b1;
               end
            end
         end
         S_DONE: begin
            w_seq_inc   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         r_type      <= '0;
         r_idx       <= '0;
         r_seq       <= '0;
         r_err       <= 1'b0;
         r_node_id   <= '0;
         r_hops      <= '0;
         r_qvalue    <= '0;
         r_energy    <= '0;
         r_hops_ch   <= '0;
         r_chosen_ch <= '0;
         r_next_hop  <= '0;
         r_next_cnt  <= '0;
         r_payload   <= '0;
      end else begin
         r_err <= w_err_set;
         if (w_snap) begin
            r_type      <= pktType;
            r_idx       <= '0;
            r_node_id   <= myNodeID;
            r_hops      <= myHops;
            r_qvalue    <= myQValue;
            r_energy    <= myEnergy;
            r_hops_ch   <= hopsFromCH;
            r_chosen_ch <= chosenCH;
            r_next_hop  <= nextHop;
            r_next_cnt  <= nextHopCount;
            r_payload   <= payload;
         end else if (w_adv) begin
            r_idx <= r_idx + 4'd1;
         end
         if (w_seq_inc) begin
            r_seq <= r_seq + 1'b1;
         end
      end
   end

   assign tx_valid = (r_state == S_SEND);
   assign tx_last  = tx_valid && w_last;
   assign tx_data  = tx_valid ? w_word : '0;
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign err      = r_err;

endmodule

// File: doc/pkt_tx_builder.md
PKT_TX_BUILDER -- requirements
Module: pkt_tx_builder

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: width of every packet word and node field.
REQ-002 SHALL have parameter SEQ_WIDTH, default 8: width of the header sequence-number field.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port nrst  input  1  synchronous, active-high reset (1 = reset; codebase port name kept).
REQ-005 SHALL have port start  input  1  one-cycle request to build and send a packet.
REQ-006 SHALL have port pktType  input  2  packet kind: 1 = HB, 2 = MR, 3 = DATA; 0 is illegal.
REQ-007 SHALL have ports myNodeID, myHops, myQValue, myEnergy, hopsFromCH, chosenCH  input  WORD_WIDTH each  own node fields.
REQ-008 SHALL have ports nextHop, nextHopCount  input  WORD_WIDTH each  next-hop result from the Q-table/find-best block.
REQ-009 SHALL have port payload  input  WORD_WIDTH  data word carried by DATA packets.
REQ-010 SHALL have port abort  input  1  heartbeat-reset abort of any packet in flight.
REQ-011 SHALL have ports tx_data  output  WORD_WIDTH, tx_valid  output  1, tx_last  output  1, and tx_ready  input  1, forming the word stream to the radio.
REQ-012 SHALL have ports busy, done, err  output  1 each  status outputs; done and err are one-cycle pulses.

Function
REQ-013 SHALL implement states S_IDLE, S_LOAD, S_SEND and S_DONE.
REQ-014 In S_IDLE with start=1, SHALL snapshot pktType and all field inputs into internal registers and go to S_LOAD; start outside S_IDLE SHALL be ignored.
REQ-015 S_LOAD SHALL last exactly one cycle: illegal pktType=0, or DATA with nextHop=16'hFFFF, pulses err and returns to S_IDLE with no words sent; otherwise it goes to S_SEND.
REQ-016 Word 0 (header) SHALL be {type[15:12], length[11:8], seq[7:0]}, with type zero-extended to 4 bits and length the total word count.
REQ-017 HB SHALL be 6 words: header, 16'hFFFF, myNodeID, myHops, myQValue, myEnergy.
REQ-018 MR SHALL be 8 words: header, chosenCH, myNodeID, myHops, myQValue, myEnergy, hopsFromCH, chosenCH.
REQ-019 DATA SHALL be 9 words: header, nextHop, myNodeID, nextHopCount, myQValue, myEnergy, hopsFromCH, chosenCH, payload.
REQ-020 In S_SEND, tx_valid SHALL be 1 and the word index SHALL advance only on a cycle where tx_valid and tx_ready are both 1.
REQ-021 tx_data and tx_last SHALL hold stable while tx_ready=0.
REQ-022 tx_last SHALL be 1 only with the final word; its handshake SHALL move to S_DONE.
REQ-023 S_DONE SHALL pulse done for one cycle, increment seq modulo 2^SEQ_WIDTH (255 wraps to 0), and return to S_IDLE.
REQ-024 abort=1 in S_LOAD or S_SEND SHALL drop tx_valid on the next cycle and return to S_IDLE without done, err or a seq increment; abort SHALL take priority over a same-cycle handshake.
REQ-025 A rejected packet SHALL NOT increment seq.
REQ-026 busy SHALL be 1 in every state except S_IDLE.
REQ-027 A new start SHALL be accepted on the cycle after done at the earliest, giving a minimum of 3 overhead cycles per packet.

Reset
REQ-028 While nrst=1, the next edge SHALL put the block in S_IDLE with tx_valid, tx_last, busy, done and err at 0, tx_data at 0, seq at 0 and snapshots cleared, aborting any packet in flight.
REQ-029 Reset SHALL override start and abort.

Structure
REQ-030 A shared package SHALL hold the pktType encodings, the packet lengths (6/8/9), the broadcast ID 16'hFFFF and the state enum.
REQ-031 The word multiplexer selecting tx_data from type and index SHALL be one combinational sub-module, pkt_word_mux.

Verification
REQ-032 HB: myNodeID=16'h0005, seq=0, tx_ready always 1 -> words 16'h1600, FFFF, 0005, ... over 6 consecutive cycles, tx_last on word 5, then done and seq=1.
REQ-033 DATA: nextHop=16'h0003, tx_ready low for 3 cycles at word 4 -> word 4 held stable, 9 words total, header 16'h39xx.
REQ-034 DATA with nextHop=16'hFFFF -> err pulse 2 cycles after start, tx_valid never 1, seq unchanged.
REQ-035 abort at word 3 of MR -> tx_valid 0 next cycle, no done, then a following HB carries the same seq.
REQ-036 256 HB packets -> the 257th header has seq=8'h00; start pulses while busy=1 are ignored.
REQ-037 nrst=1 mid-S_SEND -> all outputs 0 next cycle and seq=0.
